// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/response handshake and word-memory bus bundle for mem_lsu
interface mem_lsu_if #(parameter int ADDR_W = 11);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [1:0]        i_req_size;
  logic              i_req_unsigned;
  logic [ADDR_W-1:0] i_req_addr;
  logic [31:0]       i_req_wdata;
  logic              o_rsp_valid;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_err;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_mask;
  logic              o_mem_wren;
  logic [31:0]       i_mem_rdata;
  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren
  );
  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: byte/half/word load-store unit over a 32-bit word memory, splitting misaligned accesses
module mem_lsu #(parameter int ADDR_W = 11) (
  input logic     i_clk,
  input logic     i_reset,
  mem_lsu_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, LAST, RESP} state_t;
  state_t            state_q, state_d;
  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, word0_q, rdata_q;
  logic              accept, split;
  logic [1:0]        off;
  logic [2:0]        nbytes;
  logic [3:0]        lanes;
  logic [7:0]        mask8;
  logic [63:0]       wide_w, wide_r;
  logic [31:0]       ext;
  logic [ADDR_W-1:0] base;
  assign accept = bus.i_req_valid && bus.o_req_ready;
  assign off    = addr_q[1:0];
  assign nbytes = size_q == 2'b00 ? 3'd1 : size_q == 2'b01 ? 3'd2 : 3'd4;
  assign lanes  = size_q == 2'b00 ? 4'b0001 : size_q == 2'b01 ? 4'b0011 : 4'b1111;
  assign split  = ({1'b0, off} + nbytes) > 3'd4;
  assign mask8  = {4'b0000, lanes} << off;
  assign wide_w = {32'b0, wdata_q} << {off, 3'b000};
  assign base   = {addr_q[ADDR_W-1:2], 2'b00};
  // In LAST the live read word is word1 for a split access, otherwise it is word0 itself
  assign wide_r = (split ? {bus.i_mem_rdata, word0_q} : {32'b0, bus.i_mem_rdata}) >> {off, 3'b000};
  assign ext    = size_q == 2'b00 ? {{24{~uns_q & wide_r[7]}}, wide_r[7:0]} :
                  size_q == 2'b01 ? {{16{~uns_q & wide_r[15]}}, wide_r[15:0]} : wide_r[31:0];
  assign bus.o_req_ready = state_q == IDLE && !i_reset;
  assign bus.o_rsp_valid = state_q == RESP;
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_err   = err_q;
  // Next state and memory drive; ACC0 uses the low lane halves, ACC1 the high halves at the next word
  always_comb begin
    state_d         = state_q;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    bus.o_mem_mask  = '0;
    bus.o_mem_wren  = 1'b0;
    case (state_q)
      IDLE: state_d = accept ? (bus.i_req_size == 2'b11 ? RESP : ACC0) : IDLE;
      ACC0: begin
        state_d         = split ? ACC1 : we_q ? RESP : LAST;
        bus.o_mem_addr  = base;
        bus.o_mem_wdata = we_q ? wide_w[31:0] : '0;
        bus.o_mem_mask  = we_q ? mask8[3:0] : '0;
        bus.o_mem_wren  = we_q;
      end
      ACC1: begin
        state_d         = we_q ? RESP : LAST;
        bus.o_mem_addr  = base + ADDR_W'(4);
        bus.o_mem_wdata = we_q ? wide_w[63:32] : '0;
        bus.o_mem_mask  = we_q ? mask8[7:4] : '0;
        bus.o_mem_wren  = we_q;
      end
      LAST: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State register; reset aborts any transaction in flight
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state_q <= IDLE;
    else state_q <= state_d;
  // Request latch, first-word capture and response registers that are nonzero only in RESP
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      word0_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.i_req_we;
        uns_q   <= bus.i_req_unsigned;
        size_q  <= bus.i_req_size;
        addr_q  <= bus.i_req_addr;
        wdata_q <= bus.i_req_wdata;
      end
      if (state_q == ACC1) word0_q <= bus.i_mem_rdata;
      rdata_q <= state_q == LAST && !we_q ? ext : '0;
      err_q   <= accept && bus.i_req_size == 2'b11;
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: vector table, reset-abort sequence and random traffic against a byte-level memory model
module tb_mem_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b1;
  int total = 0;
  int bad = 0;
  int viol = 0;
  always #5 clk = ~clk;
  mem_lsu_if #(.ADDR_W(11)) bus ();
  mem_lsu #(.ADDR_W(11)) dut (.i_clk(clk), .i_reset(rst), .bus(bus.slave));
  logic [7:0]  dmem [2048];
  logic [7:0]  refm [2048];
  logic [10:0] r_addr  [0:8];
  logic [3:0]  r_mask  [0:8];
  logic [31:0] r_wdata [0:8];
  logic        r_wren  [0:8];
  // Word memory attached to the DUT: byte-masked writes, read data one cycle after the address
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 2048; i++) dmem[i] <= 8'h00;
    end else if (bus.o_mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (bus.o_mem_mask[b]) dmem[{bus.o_mem_addr[10:2], 2'b00} + 11'(b)] <= bus.o_mem_wdata[8*b +: 8];
    end
    bus.i_mem_rdata <= {dmem[{bus.o_mem_addr[10:2], 2'b11}], dmem[{bus.o_mem_addr[10:2], 2'b10}],
                        dmem[{bus.o_mem_addr[10:2], 2'b01}], dmem[{bus.o_mem_addr[10:2], 2'b00}]};
  end
  // Continuous invariants: aligned memory address, quiet response outputs between pulses
  always @(negedge clk) begin
    if (bus.o_mem_addr[1:0] != 2'b00) viol++;
    if (!bus.o_rsp_valid && (bus.o_rsp_rdata != 32'h0 || bus.o_rsp_err)) viol++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic int nbytes_of(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [10:0] a);
    int nb = nbytes_of(sz);
    logic [63:0] v = 64'h0;
    for (int i = 0; i < nb; i++) v = v | (64'(refm[(int'(a) + i) % 2048]) << (8 * i));
    if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
    return v[31:0];
  endfunction
  function automatic int model_lat(input logic we, input logic [1:0] sz, input logic [10:0] a);
    int sp = (int'(a) % 4) + nbytes_of(sz) > 4 ? 1 : 0;
    return sz == 2'd3 ? 1 : we ? 2 + sp : 3 + sp;
  endfunction
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns, input logic [10:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    chk("ready", 32'(bus.o_req_ready), 32'h1);
    bus.i_req_valid = 1'b1;
    bus.i_req_we = we;
    bus.i_req_size = sz;
    bus.i_req_unsigned = uns;
    bus.i_req_addr = a;
    bus.i_req_wdata = wd;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    bus.i_req_we = 1'($urandom);
    bus.i_req_size = 2'($urandom);
    bus.i_req_unsigned = 1'($urandom);
    bus.i_req_addr = 11'($urandom);
    bus.i_req_wdata = $urandom;
    lat = 0;
    rd = 32'h0;
    er = 1'b0;
    repeat (8) begin
      @(negedge clk);
      lat++;
      r_addr[lat] = bus.o_mem_addr;
      r_mask[lat] = bus.o_mem_mask;
      r_wdata[lat] = bus.o_mem_wdata;
      r_wren[lat] = bus.o_mem_wren;
      if (bus.o_rsp_valid) begin
        rd = bus.o_rsp_rdata;
        er = bus.o_rsp_err;
        break;
      end
    end
  endtask
  task automatic do_txn(input string nm, input logic we, input logic [1:0] sz, input logic uns, input logic [10:0] a,
                        input logic [31:0] wd, input logic [31:0] xrd, input logic xer, input int xlat);
    int lat;
    logic [31:0] rd;
    logic er;
    run_txn(we, sz, uns, a, wd, lat, rd, er);
    chk({nm, "_lat"}, 32'(lat), 32'(xlat));
    chk({nm, "_rdata"}, rd, xrd);
    chk({nm, "_err"}, 32'(er), 32'(xer));
    if (we && sz != 2'd3)
      for (int i = 0; i < nbytes_of(sz); i++) refm[(int'(a) + i) % 2048] = wd[8*i +: 8];
  endtask
  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [10:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
  } vec_t;
  vec_t tbl [14];
  initial begin
    int nrsp;
    int nwr;
    bus.i_req_valid = 1'b0;
    bus.i_req_we = 1'b0;
    bus.i_req_size = 2'b00;
    bus.i_req_unsigned = 1'b0;
    bus.i_req_addr = '0;
    bus.i_req_wdata = '0;
    for (int i = 0; i < 2048; i++) refm[i] = 8'h00;
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 11'h01C, 32'h80FF1234, 32'h0, 1'b0, 2};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, 11'h7FC, 32'hAABBCCDD, 32'h0, 1'b0, 2};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 11'h000, 32'h11223344, 32'h0, 1'b0, 2};
    tbl[3]  = '{1'b1, 2'd2, 1'b0, 11'h008, 32'hDEADBEEF, 32'h0, 1'b0, 2};
    tbl[4]  = '{1'b1, 2'd1, 1'b0, 11'h013, 32'h00005678, 32'h0, 1'b0, 3};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 11'h01F, 32'h0, 32'hFFFFFF80, 1'b0, 3};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 11'h01F, 32'h0, 32'h00000080, 1'b0, 3};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 11'h7FE, 32'h0, 32'h3344AABB, 1'b0, 4};
    tbl[8]  = '{1'b1, 2'd3, 1'b0, 11'h123, 32'hFFFFFFFF, 32'h0, 1'b1, 1};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 11'h008, 32'h0, 32'hDEADBEEF, 1'b0, 3};
    tbl[10] = '{1'b0, 2'd1, 1'b1, 11'h013, 32'h0, 32'h00005678, 1'b0, 4};
    tbl[11] = '{1'b0, 2'd1, 1'b0, 11'h012, 32'h0, 32'h00007800, 1'b0, 3};
    tbl[12] = '{1'b0, 2'd1, 1'b0, 11'h01E, 32'h0, 32'hFFFF80FF, 1'b0, 3};
    tbl[13] = '{1'b0, 2'd3, 1'b1, 11'h7FF, 32'h0, 32'h0, 1'b1, 1};
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.o_req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
    chk("rst_mem", {bus.o_mem_wdata[27:0], bus.o_mem_mask}, 32'h0);
    chk("rst_wren", 32'(bus.o_mem_wren), 32'h0);
    clr = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.o_req_ready), 32'h1);
    for (int i = 0; i < 14; i++) begin
      do_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].er, tbl[i].lat);
      if (i == 3) begin
        chk("w_acc0_addr", 32'(r_addr[1]), 32'h008);
        chk("w_acc0_mask", 32'(r_mask[1]), 32'hF);
        chk("w_acc0_wdata", r_wdata[1], 32'hDEADBEEF);
        chk("w_acc0_wren", 32'(r_wren[1]), 32'h1);
        chk("w_resp_wren", 32'(r_wren[2]), 32'h0);
      end
      if (i == 4) begin
        chk("h_acc0_addr", 32'(r_addr[1]), 32'h010);
        chk("h_acc0_mask", 32'(r_mask[1]), 32'h8);
        chk("h_acc0_byte", 32'(r_wdata[1][31:24]), 32'h78);
        chk("h_acc1_addr", 32'(r_addr[2]), 32'h014);
        chk("h_acc1_mask", 32'(r_mask[2]), 32'h1);
        chk("h_acc1_byte", 32'(r_wdata[2][7:0]), 32'h56);
        chk("h_acc1_wren", 32'(r_wren[2]), 32'h1);
      end
      if (i == 7) begin
        chk("wrap_acc0_addr", 32'(r_addr[1]), 32'h7FC);
        chk("wrap_acc1_addr", 32'(r_addr[2]), 32'h000);
        chk("wrap_load_mask", 32'({r_mask[1], r_mask[2], 3'b000, r_wren[1], 3'b000, r_wren[2]}), 32'h0);
      end
      if (i == 8) chk("illegal_quiet", 32'({r_mask[1], 3'b000, r_wren[1]}), 32'h0);
    end
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_we = 1'b1;
    bus.i_req_size = 2'd1;
    bus.i_req_unsigned = 1'b0;
    bus.i_req_addr = 11'h1F3;
    bus.i_req_wdata = 32'h0000ABCD;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    chk("abort_acc0_wren", 32'(bus.o_mem_wren), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("abort_wren_drop", 32'(bus.o_mem_wren), 32'h0);
    chk("abort_ready_low", 32'(bus.o_req_ready), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.o_req_ready), 32'h1);
    nrsp = 0;
    nwr = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_rsp_valid) nrsp++;
      if (bus.o_mem_wren) nwr++;
    end
    chk("abort_no_rsp", 32'(nrsp), 32'h0);
    chk("abort_no_write", 32'(nwr), 32'h0);
    do_txn("abort_mem", 1'b0, 2'd2, 1'b1, 11'h1F4, 32'h0, model_load(2'd2, 1'b1, 11'h1F4), 1'b0, 3);
    for (int k = 0; k < 150; k++) begin
      logic we;
      logic [1:0] sz;
      logic uns;
      logic [10:0] a;
      logic [31:0] wd;
      we = 1'($urandom);
      sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      uns = 1'($urandom);
      a = 11'((2016 + $urandom_range(0, 95)) % 2048);
      wd = $urandom;
      do_txn($sformatf("rnd%0d", k), we, sz, uns, a, wd,
             (we || sz == 2'd3) ? 32'h0 : model_load(sz, uns, a), sz == 2'd3, model_lat(we, sz, a));
    end
    chk("monitor", 32'(viol), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter: ADDR_W, default 11, byte-address width of the attached memory.
REQ-002 Port: i_clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-003 Port: i_reset  input  1  asynchronous, active-high reset.
REQ-004 Port: i_req_valid  input  1  request present.
REQ-005 Port: o_req_ready  output  1  high only in IDLE with i_reset low; a request is accepted when i_req_valid and o_req_ready are both high.
REQ-006 Port: i_req_we  input  1  1=store, 0=load.
REQ-007 Port: i_req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 Port: i_req_unsigned  input  1  load zero-extend (1) or sign-extend (0).
REQ-009 Port: i_req_addr  input  ADDR_W  byte address; any alignment.
REQ-010 Port: i_req_wdata  input  32  store data, right-justified.
REQ-011 Port: o_rsp_valid  output  1  one-cycle completion pulse; consumer always accepts it.
REQ-012 Port: o_rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 Port: o_rsp_err  output  1  qualifies o_rsp_valid; illegal size.
REQ-014 Port: o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren  output  ADDR_W/32/4/1  memory drive; o_mem_addr[1:0] always 00.
REQ-015 Port: i_mem_rdata  input  32  memory read data, valid one cycle after o_mem_addr is driven.

Function
REQ-016 States: IDLE, ACC0, ACC1, LAST, RESP; request fields are latched on acceptance; i_req_* are ignored outside IDLE.
REQ-017 off = addr[1:0]; nbytes = 1/2/4 by size; split = (off + nbytes > 4).
REQ-018 Transitions: IDLE->ACC0 on accept with legal size; IDLE->RESP on accept with size 11 (err=1, no memory access); ACC0->ACC1 if split, else LAST for load, else RESP for store; ACC1->LAST for load, else RESP; LAST->RESP; RESP->IDLE.
REQ-019 ACC0 drives word address {addr[ADDR_W-1:2],00}; ACC1 drives that address + 4, taken modulo 2^ADDR_W (so 0x7FC wraps to 0x000).
REQ-020 Store lanes: 64-bit data = wdata << 8*off; 8-bit mask = ((1<<nbytes)-1) << off; ACC0 uses the low halves and ACC1 the high halves; o_mem_wren = 1 in ACC0/ACC1 for stores only.
REQ-021 For loads, o_mem_mask = 0 and o_mem_wren = 0; outside ACC0/ACC1, all o_mem_* outputs = 0.
REQ-022 Load capture: i_mem_rdata is captured as word0 in ACC1 and as the final word in LAST (word0 when not split, word1 when split); result = ({word1,word0} >> 8*off) truncated to nbytes, then extended per i_req_unsigned.
REQ-023 Latency from the acceptance edge T, measured as the cycle in which o_rsp_valid is high: load T+3 (split T+4); store T+2 (split T+3); illegal size T+1.
REQ-024 o_rsp_rdata and o_rsp_err are registered and valid only while o_rsp_valid is high; they are 0 otherwise.
REQ-025 Back-to-back: a new request is accepted no earlier than the cycle after RESP; at most one transaction is outstanding.

Reset
REQ-026 While i_reset is high: state = IDLE; all outputs = 0, including o_req_ready; captured words and latched request = 0.
REQ-027 A reset asserted mid-transaction aborts it immediately: o_mem_wren drops in the same cycle, no remaining access is issued, and no response is produced.

Verification
REQ-028 Store word 0xDEADBEEF to 0x008 -> ACC0: addr 0x008, mask 1111, wdata 0xDEADBEEF, wren=1 for one cycle; o_rsp_valid at T+2.
REQ-029 Store half 0x5678 to 0x013 -> ACC0: addr 0x010, mask 1000, wdata[31:24]=0x78; ACC1: addr 0x014, mask 0001, wdata[7:0]=0x56; response at T+3.
REQ-030 Word at 0x01C = 0x80FF1234; load byte from 0x01F -> signed load returns 0xFFFFFF80; unsigned load returns 0x00000080; response at T+3.
REQ-031 Word 0x7FC = 0xAABBCCDD and word 0x000 = 0x11223344; load word from 0x7FE -> accesses 0x7FC then 0x000; rdata 0x3344AABB at T+4.
REQ-032 Size 11 at any address -> o_rsp_valid with err=1 and rdata 0 at T+1; o_mem_wren and o_mem_mask stay 0 throughout.
REQ-033 Assert i_reset during ACC0 of a split store -> wren=0 immediately and no ACC1 write occurs; after release, o_req_ready=1 and no o_rsp_valid is produced.
